// File: rtl/symcount_pkg.sv
// Shared types and constants for the symbol-counting game controller.
package symcount_pkg;
  localparam int COUNT_W = 5;
  localparam int LEVEL_W = 4;
  localparam int PASS_TOLERANCE = 2;
  localparam int unsigned COUNT_MAX = (1 << COUNT_W) - 1;

  typedef enum logic [2:0] {
    IDLE, ARM, COUNT, REPORT, VERDICT, NEXT, OVER, WIN
  } state_t;

  function automatic logic [COUNT_W-1:0] sat_count(input int unsigned v);
    return (v > COUNT_MAX) ? COUNT_W'(COUNT_MAX) : COUNT_W'(v);
  endfunction

  function automatic logic [COUNT_W-1:0] abs_diff(input logic [COUNT_W-1:0] a,
                                                   input logic [COUNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/level_sequencer_sec_tick.sv
// One-second prescaler: one-cycle tick every TICKS_PER_SEC cycles, restarted by clr.
// Tick lands on the TICKS_PER_SEC-th cycle after clr drops; no backpressure.
module sec_tick #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  assign tick = !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: per-level target, timed counting window, press tally, judge handshake.
// Outputs registered or decoded from state; pulse inputs, no backpressure; RANDOM_TARGET_EN adds LFSR jitter to target.
module level_sequencer
  import symcount_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int WINDOW_SEC    = 5,
  parameter int BASE_SYMBOLS  = 4,
  parameter int MAX_LEVEL     = 15,
  parameter int VERDICT_WAIT  = 4
) (
  input  logic               Clk100M,
  input  logic               Rst,
  input  logic               start,
  input  logic               press,
  input  logic               incLevel,
  input  logic               lose,
  output logic [LEVEL_W-1:0] level,
  output logic [COUNT_W-1:0] target_count,
  output logic [2:0]         time_left,
  output logic               playing,
  output logic               levelComplete,
  output logic [COUNT_W-1:0] difference,
  output logic               game_over,
  output logic               win
);
  localparam int VW = (VERDICT_WAIT > 1) ? $clog2(VERDICT_WAIT) : 1;

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [COUNT_W-1:0] target_q, target_d;
  logic [COUNT_W-1:0] press_q, press_d;
  logic [COUNT_W-1:0] diff_q, diff_d;
  logic [2:0]         time_q, time_d;
  logic [VW-1:0]      vwait_q, vwait_d;
  logic               tick_clr, tick;
  logic [1:0]         rand_add;

`ifdef RANDOM_TARGET_EN
  logic [7:0] lfsr_q, lfsr_d;
  // Galois form of x^8+x^6+x^5+x^4+1; maximal length, so a nonzero seed never hits zero
  always_comb lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  always_ff @(posedge Clk100M) begin
    if (Rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end
  assign rand_add = lfsr_q[1:0];
`else
  assign rand_add = 2'd0;
`endif

  sec_tick #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_tick (
    .clk  (Clk100M),
    .rst  (Rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    press_d  = press_q;
    diff_d   = diff_q;
    time_d   = time_q;
    vwait_d  = vwait_q;
    tick_clr = 1'b0;
    case (state_q)
      IDLE, OVER, WIN: begin
        if (start) begin
          state_d = ARM;
          level_d = '0;
        end
      end
      ARM: begin
        target_d = sat_count(32'(BASE_SYMBOLS) + 32'(level_q) + 32'(rand_add));
        press_d  = '0;
        diff_d   = '0;
        time_d   = 3'(WINDOW_SEC);
        tick_clr = 1'b1;
        state_d  = COUNT;
      end
      COUNT: begin
        if (press && press_q != COUNT_W'(COUNT_MAX)) press_d = press_q + 1'b1;
        if (tick) begin
          time_d = time_q - 1'b1;
          // a press on the closing tick is already folded into press_d
          if (time_q == 3'd1) begin
            state_d = REPORT;
            diff_d  = abs_diff(press_d, target_q);
          end
        end
      end
      REPORT: begin
        state_d = VERDICT;
        vwait_d = '0;
      end
      VERDICT: begin
        if (lose)                                state_d = OVER;
        else if (incLevel)                       state_d = NEXT;
        else if (vwait_q == VW'(VERDICT_WAIT - 1))
          state_d = (diff_q <= COUNT_W'(PASS_TOLERANCE)) ? NEXT : OVER;
        else                                     vwait_d = vwait_q + 1'b1;
      end
      NEXT: begin
        if (level_q == LEVEL_W'(MAX_LEVEL)) begin
          state_d = WIN;
        end else begin
          level_d = level_q + 1'b1;
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      state_q  <= IDLE;
      level_q  <= '0;
      target_q <= '0;
      press_q  <= '0;
      diff_q   <= '0;
      time_q   <= '0;
      vwait_q  <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      press_q  <= press_d;
      diff_q   <= diff_d;
      time_q   <= time_d;
      vwait_q  <= vwait_d;
    end
  end

  assign level         = level_q;
  assign target_count  = target_q;
  assign time_left     = time_q;
  assign difference    = diff_q;
  assign playing       = (state_q == ARM) || (state_q == COUNT) ||
                         (state_q == REPORT) || (state_q == VERDICT);
  assign levelComplete = (state_q == REPORT);
  assign game_over     = (state_q == OVER);
  assign win           = (state_q == WIN);
endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench: table of level windows plus hand sequences for win and mid-window reset.
module tb_level_sequencer;
  localparam int M_NONE = 0;
  localparam int M_INC  = 1;
  localparam int M_LOSE = 2;
  localparam int M_BOTH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, press, inc_level, lose;
  logic [3:0] level, level_w;
  logic [4:0] target_count, target_w, difference, diff_w;
  logic [2:0] time_left, time_w;
  logic       playing, playing_w, lc, lc_w, game_over, go_w, win, win_w;

  int checks = 0;
  int failures = 0;

  level_sequencer #(.TICKS_PER_SEC(10), .MAX_LEVEL(15)) dut (
    .Clk100M(clk), .Rst(rst), .start(start), .press(press), .incLevel(inc_level), .lose(lose),
    .level(level), .target_count(target_count), .time_left(time_left), .playing(playing),
    .levelComplete(lc), .difference(difference), .game_over(game_over), .win(win)
  );

  level_sequencer #(.TICKS_PER_SEC(10), .MAX_LEVEL(2)) dut_w (
    .Clk100M(clk), .Rst(rst), .start(start), .press(press), .incLevel(inc_level), .lose(lose),
    .level(level_w), .target_count(target_w), .time_left(time_w), .playing(playing_w),
    .levelComplete(lc_w), .difference(diff_w), .game_over(go_w), .win(win_w)
  );

  typedef struct {
    string name;
    int    first;
    int    last;
    int    start_at;
    int    mode;
    int    exp_tgt;
    int    exp_diff;
    bit    exp_over;
    int    exp_level;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string p, input logic [3:0] lv, input logic [4:0] tg,
                          input logic [2:0] tl, input logic pl, input logic lcv,
                          input logic [4:0] df, input logic go, input logic wn);
    chk({p, ".level"}, int'(lv), 0);
    chk({p, ".target"}, int'(tg), 0);
    chk({p, ".time_left"}, int'(tl), 0);
    chk({p, ".playing"}, int'(pl), 0);
    chk({p, ".levelComplete"}, int'(lcv), 0);
    chk({p, ".difference"}, int'(df), 0);
    chk({p, ".game_over"}, int'(go), 0);
    chk({p, ".win"}, int'(wn), 0);
  endtask

  // Entered with the DUT in ARM; leaves it one cycle after the first VERDICT cycle.
  task automatic play_level(input int first, input int last, input int start_at, input int mode,
                            output int k, output int tgt, output int dif);
    bit seen;
    k = 0; seen = 1'b0; tgt = -1; dif = -1;
    while (!seen && k < 200) begin
      press = (k >= first && k <= last);
      start = (k == start_at);
      step;
      k++;
      if (k == 1) tgt = int'(target_count);
      if (lc) begin
        seen = 1'b1;
        dif  = int'(difference);
      end
    end
    start = 1'b0;
    press = (k >= first && k <= last);
    step;
    press     = 1'b0;
    inc_level = (mode & 1) != 0;
    lose      = (mode & 2) != 0;
    step;
    inc_level = 1'b0;
    lose      = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   k, tgt, dif;
    v = vecs[i];
    play_level(v.first, v.last, v.start_at, v.mode, k, tgt, dif);
    chk({v.name, ".lc_cycles"}, k, 51);
    chk({v.name, ".target"}, tgt, v.exp_tgt);
    chk({v.name, ".difference"}, dif, v.exp_diff);
    if (v.mode == M_NONE) begin
      step;
      step;
      chk({v.name, ".v4_playing"}, int'(playing), 1);
      step;
    end
    if (v.exp_over) begin
      chk({v.name, ".game_over"}, int'(game_over), 1);
      chk({v.name, ".over_playing"}, int'(playing), 0);
      chk({v.name, ".diff_held"}, int'(difference), v.exp_diff);
      start = 1'b1;
      step;
      start = 1'b0;
      chk({v.name, ".restart_level"}, int'(level), 0);
      chk({v.name, ".restart_game_over"}, int'(game_over), 0);
    end else begin
      chk({v.name, ".next_playing"}, int'(playing), 0);
      chk({v.name, ".next_game_over"}, int'(game_over), 0);
      step;
      chk({v.name, ".arm_level"}, int'(level), v.exp_level);
      chk({v.name, ".arm_playing"}, int'(playing), 1);
    end
  endtask

  initial begin
    vecs[0] = '{"l0_pass_lose_held", 1, 4, 20, M_INC, 4, 0, 1'b0, 1};
    vecs[1] = '{"l1_pass", 1, 5, -1, M_INC, 5, 0, 1'b0, 2};
    vecs[2] = '{"l2_pass", 1, 6, -1, M_INC, 6, 0, 1'b0, 3};
    vecs[3] = '{"l0_lose", 1, 7, -1, M_LOSE, 4, 3, 1'b1, 0};
    vecs[4] = '{"l0_timeout_over", 1, 8, -1, M_NONE, 4, 4, 1'b1, 0};
    vecs[5] = '{"l0_timeout_next", 1, 5, -1, M_NONE, 4, 1, 1'b0, 1};
    vecs[6] = '{"l1_both_high", 1, 0, -1, M_BOTH, 5, 5, 1'b1, 0};
    vecs[7] = '{"l0_saturate", 1, 40, -1, M_LOSE, 4, 27, 1'b1, 0};
    vecs[8] = '{"l0_final_tick", 50, 51, -1, M_LOSE, 4, 3, 1'b1, 0};

    rst = 1'b1; start = 1'b0; press = 1'b0; inc_level = 1'b0;
    lose = 1'b1;  // held from power-up through IDLE, ARM and COUNT of the first level
    step;
    step;
    chk_idle("reset", level, target_count, time_left, playing, lc, difference, game_over, win);
    rst = 1'b0;
    step;
    start = 1'b1;
    step;
    start = 1'b0;

    for (int i = 0; i < 3; i++) run_vec(i);

    chk("win.win", int'(win_w), 1);
    chk("win.level", int'(level_w), 2);
    chk("win.playing", int'(playing_w), 0);

    step;
    chk("mid.level", int'(level), 3);
    chk("mid.target", int'(target_count), 7);
    chk("mid.time_left", int'(time_left), 5);
    press = 1'b1;
    step;
    step;
    press = 1'b0;
    rst = 1'b1;
    step;
    chk_idle("mid_rst", level, target_count, time_left, playing, lc, difference, game_over, win);
    chk_idle("mid_rst_w", level_w, target_w, time_w, playing_w, lc_w, diff_w, go_w, win_w);
    rst = 1'b0;
    step;
    start = 1'b1;
    step;
    start = 1'b0;

    for (int i = 3; i < 9; i++) run_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
